cacheline_adapter: RTL and testbench
====================================

Name: cacheline_adapter

Overview:
- Sits directly downstream of the instruction cache's fill port (dfp_*). It converts one 256-bit line request into a 4-beat, 64-bit burst on the banked memory interface (bmem_*).
- Reads: collects 4 returned beats into one line, then pulses dfp_resp.
- Writes: serialises the latched line into 4 beats, then pulses dfp_resp.
- One transaction in flight at a time.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory beat width in bits; BEATS = LINE_W/BEAT_W = 4.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 resets the block immediately, independent of clk.
- dfp_addr  in  ADDR_W  line address from cache; bits [4:0] ignored and forced to 0.
- dfp_read  in  1  line read request; held high until dfp_resp.
- dfp_write  in  1  line write request; held high until dfp_resp.
- dfp_wdata  in  LINE_W  line to write; sampled at acceptance.
- dfp_rdata  out  LINE_W  assembled read line; valid while dfp_resp=1.
- dfp_resp  out  1  single-cycle completion pulse.
- bmem_addr  out  ADDR_W  burst base address, line-aligned.
- bmem_read  out  1  burst read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_W  write beat data.
- bmem_ready  in  1  memory accepts command/beat this cycle.
- bmem_raddr  in  ADDR_W  address tag of the returning read beat.
- bmem_rdata  in  BEAT_W  read beat data.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset (rst=0):
  - state=IDLE, beat counter=0, line buffer=0, latched addr=0.
  - All outputs 0: dfp_resp, dfp_rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata.
  - Reset mid-burst aborts the transaction. No dfp_resp is produced. Beats arriving after reset are dropped.
- States: IDLE, RD_CMD, RD_DATA, WR_BEAT, DONE.
- IDLE:
  - If dfp_write=1, latch {dfp_addr[31:5],5'b0} and dfp_wdata, clear counter, go to WR_BEAT.
  - Else if dfp_read=1, latch the address, clear counter, go to RD_CMD.
  - Write wins when both are asserted.
  - bmem_rvalid in IDLE is ignored.
- RD_CMD:
  - bmem_read=1, bmem_addr=latched addr.
  - Held until a cycle with bmem_ready=1, then go to RD_DATA; bmem_read drops next cycle.
  - Exactly one read command per line.
- RD_DATA:
  - Each cycle with bmem_rvalid=1 and bmem_raddr==latched addr: write beat into line bits [64k+63:64k], where k=counter, then increment counter.
  - Beats with a mismatched raddr are discarded.
  - Beats may be non-consecutive, with any number of idle cycles between them.
  - After beat 3 is accepted, go to DONE.
- WR_BEAT:
  - bmem_write=1, bmem_addr=latched addr, bmem_wdata=line[64k+63:64k].
  - On bmem_ready=1, k increments.
  - Data is held stable while bmem_ready=0.
  - After beat 3 is accepted, go to DONE.
- DONE:
  - dfp_resp=1 for exactly one cycle. dfp_rdata = the assembled line for reads; it is don't-care after writes and is driven 0.
  - Unconditionally return to IDLE.
  - dfp_read/dfp_write sampled in DONE are ignored. The cache drops its request in the cycle after dfp_resp.
- Latency:
  - Read: min 1 (IDLE) + 1 (RD_CMD) + 4 beats + 1 (DONE). With bmem_ready=1 and beats back-to-back starting the cycle after the command, dfp_resp occurs 7 cycles after dfp_read is first seen.
  - Write with bmem_ready=1 throughout: dfp_resp occurs 6 cycles after dfp_write.
- Counter: 2 bits. Wraps 3→0 only on the transition to DONE; it never increments outside RD_DATA/WR_BEAT.
- dfp_rdata is registered and holds its value until the next read completes. The line buffer is cleared only by reset.

Test Plan:
- Read, addr 0x0000_1234: expect bmem_addr=0x0000_1220 and one bmem_read accepted. Return beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back → dfp_rdata={0x44..44,0x33..33,0x22..22,0x11..11}, dfp_resp high exactly 1 cycle, 7 cycles after request.
- Read with bmem_ready low for 5 cycles, then beats separated by 3 idle cycles each → bmem_read held 6 cycles, same assembled line, single dfp_resp.
- Read with an interleaved stray beat where raddr=0x0000_2000 → stray beat discarded, line matches only the correctly tagged beats.
- Write, addr 0x0000_0040, line bytes 0x00..0x1F, bmem_ready toggling 1,0,1,0,... → bmem_wdata = beats 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110, 0x1F1E1D1C1B1A1918 in order, each held across ready=0 cycles, one dfp_resp.
- dfp_read and dfp_write both high in IDLE → write burst performed, no bmem_read issued.
- rst pulsed low after beat 2 of a read → all outputs 0 immediately, no dfp_resp. Late beats are ignored. A subsequent read completes correctly with a fresh line.

Source files
------------

// File: rtl/cacheline_adapter_if.sv
// Cache fill port (dfp_*) and banked memory burst port (bmem_*) of the cacheline adapter.
// The slave modport is the adapter's view; master is the cache/memory environment.
interface cacheline_adapter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64
);
  logic [ADDR_W-1:0] dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts one cache-line request into a BEATS-long burst on the banked memory port,
// assembling read beats into a line or serialising a latched line into write beats.
module cacheline_adapter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  cacheline_adapter_if.slave  bus
);
  localparam int unsigned BEATS  = LINE_W / BEAT_W;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned SEL_W  = $clog2(LINE_W);
  localparam int unsigned BSH    = $clog2(BEAT_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_CMD  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_BEAT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_rdata;
  logic              r_is_wr;

  logic [ADDR_W-1:0] w_line_addr;
  logic [SEL_W-1:0]  w_base;
  logic              w_last;
  logic              w_beat_hit;
  logic [LINE_W-1:0] w_line_merged;

  assign w_line_addr = bus.dfp_addr & ~OFF_MASK;
  assign w_base      = SEL_W'(r_cnt) << BSH;
  assign w_last      = (r_cnt == CNT_W'(BEATS - 1));
  // Only beats tagged with this line's base address belong to the current burst.
  assign w_beat_hit  = bus.bmem_rvalid && (bus.bmem_raddr == r_addr);

  always_comb begin
    w_line_merged = r_line;
    w_line_merged[w_base +: BEAT_W] = bus.bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_line  <= '0;
      r_rdata <= '0;
      r_is_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.dfp_write) begin
            r_addr  <= w_line_addr;
            r_line  <= bus.dfp_wdata;
            r_cnt   <= '0;
            r_is_wr <= 1'b1;
            r_state <= S_WR_BEAT;
          end else if (bus.dfp_read) begin
            r_addr  <= w_line_addr;
            r_cnt   <= '0;
            r_is_wr <= 1'b0;
            r_state <= S_RD_CMD;
          end
        end
        S_RD_CMD: begin
          if (bus.bmem_ready) r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (w_beat_hit) begin
            r_line <= w_line_merged;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              r_rdata <= w_line_merged;
              r_state <= S_DONE;
            end
          end
        end
        S_WR_BEAT: begin
          if (bus.bmem_ready) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Completed read line stays visible across later writes; only a write's own DONE shows zero.
  assign bus.dfp_resp   = (r_state == S_DONE);
  assign bus.dfp_rdata  = (r_state == S_DONE && r_is_wr) ? '0 : r_rdata;
  assign bus.bmem_read  = (r_state == S_RD_CMD);
  assign bus.bmem_write = (r_state == S_WR_BEAT);
  assign bus.bmem_addr  = (r_state == S_RD_CMD || r_state == S_WR_BEAT) ? r_addr : '0;
  assign bus.bmem_wdata = (r_state == S_WR_BEAT) ? r_line[w_base +: BEAT_W] : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: acts as cache and memory, compares against hand-computed values.
module tb_cacheline_adapter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adapter_if #(.ADDR_W(32), .LINE_W(256), .BEAT_W(64)) bus ();

  cacheline_adapter #(.LINE_W(256), .BEAT_W(64), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rd_acc   = 0;
  int resp_cnt = 0;
  logic [63:0] wq[$];
  logic [63:0] beats [4];

  always @(posedge clk) begin
    if (bus.bmem_read && bus.bmem_ready) rd_acc++;
    if (bus.dfp_resp) resp_cnt++;
    if (bus.bmem_write && bus.bmem_ready) wq.push_back(bus.bmem_wdata);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_read(input logic [31:0] addr, input int ready_delay, input int gap,
                          input bit stray, output int lat, output logic [255:0] line,
                          output int rd_hi, output logic [31:0] addr_seen);
    int sent, gapc, cyc;
    bit cmd_done, stray_done;
    sent = 0; gapc = 0; cyc = 1; cmd_done = 0; stray_done = 0;
    rd_hi = 0; lat = -1; line = '1; addr_seen = '0;
    bus.dfp_addr = addr; bus.dfp_read = 1'b1;
    bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(); cyc++;
      if (bus.dfp_resp) begin
        lat = cyc; line = bus.dfp_rdata;
        break;
      end
      bus.bmem_rvalid = 1'b0;
      if (bus.bmem_read) begin
        if (rd_hi == 0) addr_seen = bus.bmem_addr;
        rd_hi++;
      end
      if (!cmd_done) begin
        if (bus.bmem_read && rd_hi > ready_delay) begin
          bus.bmem_ready = 1'b1; cmd_done = 1;
        end
      end else begin
        bus.bmem_ready = 1'b0;
        if (gapc > 0) gapc--;
        else if (sent < 4) begin
          bus.bmem_rvalid = 1'b1;
          if (stray && sent == 2 && !stray_done) begin
            bus.bmem_raddr = 32'h0000_2000;
            bus.bmem_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
            stray_done = 1;
          end else begin
            bus.bmem_raddr = addr & ~32'h1F;
            bus.bmem_rdata = beats[sent];
            sent++; gapc = gap;
          end
        end
      end
    end
    bus.dfp_read = 1'b0; bus.bmem_rvalid = 1'b0; bus.bmem_ready = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [255:0] line, input bit toggle,
                           input bit also_read, output int lat, output logic [31:0] addr_seen,
                           output logic [255:0] rdata_seen, output int stab_err);
    int cyc, ph;
    bit hold;
    logic [63:0] prev_w;
    cyc = 1; ph = 0; hold = 0; prev_w = '0; lat = -1;
    addr_seen = '0; rdata_seen = '1; stab_err = 0;
    wq.delete();
    bus.dfp_addr = addr; bus.dfp_wdata = line;
    bus.dfp_write = 1'b1; bus.dfp_read = also_read; bus.bmem_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(); cyc++;
      if (bus.dfp_resp) begin
        lat = cyc; rdata_seen = bus.dfp_rdata;
        break;
      end
      if (hold && bus.bmem_wdata !== prev_w) stab_err++;
      if (bus.bmem_write) begin
        if (ph == 0) addr_seen = bus.bmem_addr;
        bus.bmem_ready = toggle ? (ph % 2 == 0) : 1'b1;
        ph++;
        hold = !bus.bmem_ready;
        prev_w = bus.bmem_wdata;
      end else begin
        bus.bmem_ready = 1'b0;
        hold = 0;
      end
    end
    bus.dfp_write = 1'b0; bus.dfp_read = 1'b0; bus.bmem_ready = 1'b0;
  endtask

  initial begin
    int lat, rd_hi, stab, r0, a0;
    logic [255:0] line, wline;
    logic [31:0]  aseen;

    rst = 1'b0;
    bus.dfp_addr = '0; bus.dfp_read = 1'b0; bus.dfp_write = 1'b0; bus.dfp_wdata = '0;
    bus.bmem_ready = 1'b0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    tick(); tick();
    check("rst_resp",  256'(bus.dfp_resp),   256'(0));
    check("rst_rdata", bus.dfp_rdata,        256'(0));
    check("rst_bread", 256'(bus.bmem_read),  256'(0));
    check("rst_bwr",   256'(bus.bmem_write), 256'(0));
    check("rst_baddr", 256'(bus.bmem_addr),  256'(0));
    check("rst_bwd",   256'(bus.bmem_wdata), 256'(0));
    rst = 1'b1;
    tick();

    // Back-to-back read
    beats[0] = 64'h1111_1111_1111_1111; beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333; beats[3] = 64'h4444_4444_4444_4444;
    r0 = resp_cnt; a0 = rd_acc;
    run_read(32'h0000_1234, 0, 0, 0, lat, line, rd_hi, aseen);
    tick(); tick();
    check("t1_addr",  256'(aseen), 256'(32'h0000_1220));
    check("t1_lat",   256'(lat), 256'(7));
    check("t1_line",  line, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    check("t1_rdhi",  256'(rd_hi), 256'(1));
    check("t1_rdacc", 256'(rd_acc - a0), 256'(1));
    check("t1_resp",  256'(resp_cnt - r0), 256'(1));

    // Slow command acceptance and spaced beats
    r0 = resp_cnt; a0 = rd_acc;
    run_read(32'h0000_5678, 5, 3, 0, lat, line, rd_hi, aseen);
    tick(); tick();
    check("t2_addr",  256'(aseen), 256'(32'h0000_5660));
    check("t2_rdhi",  256'(rd_hi), 256'(6));
    check("t2_lat",   256'(lat), 256'(21));
    check("t2_line",  line, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    check("t2_rdacc", 256'(rd_acc - a0), 256'(1));
    check("t2_resp",  256'(resp_cnt - r0), 256'(1));

    // Stray beat with foreign tag
    beats[0] = 64'hAAAA_AAAA_AAAA_AAAA; beats[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    beats[2] = 64'hCCCC_CCCC_CCCC_CCCC; beats[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    r0 = resp_cnt;
    run_read(32'h0000_3000, 0, 0, 1, lat, line, rd_hi, aseen);
    tick(); tick();
    check("t3_line", line, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
    check("t3_lat",  256'(lat), 256'(8));
    check("t3_resp", 256'(resp_cnt - r0), 256'(1));

    // Write with toggling ready
    for (int b = 0; b < 32; b++) wline[b*8 +: 8] = 8'(b);
    r0 = resp_cnt; a0 = rd_acc;
    run_write(32'h0000_0040, wline, 1, 0, lat, aseen, line, stab);
    tick(); tick();
    check("t4_addr",  256'(aseen), 256'(32'h0000_0040));
    check("t4_lat",   256'(lat), 256'(9));
    check("t4_nbeat", 256'(wq.size()), 256'(4));
    check("t4_beat0", 256'((wq.size() > 0) ? wq[0] : 64'hx), 256'(64'h0706_0504_0302_0100));
    check("t4_beat1", 256'((wq.size() > 1) ? wq[1] : 64'hx), 256'(64'h0F0E_0D0C_0B0A_0908));
    check("t4_beat2", 256'((wq.size() > 2) ? wq[2] : 64'hx), 256'(64'h1716_1514_1312_1110));
    check("t4_beat3", 256'((wq.size() > 3) ? wq[3] : 64'hx), 256'(64'h1F1E_1D1C_1B1A_1918));
    check("t4_stable", 256'(stab), 256'(0));
    check("t4_rdata", line, 256'(0));
    check("t4_resp",  256'(resp_cnt - r0), 256'(1));
    check("t4_rdacc", 256'(rd_acc - a0), 256'(0));
    check("t4_hold_rdata", bus.dfp_rdata, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});

    // Read and write together: write wins
    wline = {64'hD0D0_D0D0_0000_0004, 64'hC0C0_C0C0_0000_0003,
             64'hB0B0_B0B0_0000_0002, 64'hA0A0_A0A0_0000_0001};
    r0 = resp_cnt; a0 = rd_acc;
    run_write(32'h0000_009C, wline, 0, 1, lat, aseen, line, stab);
    tick(); tick();
    check("t5_addr",  256'(aseen), 256'(32'h0000_0080));
    check("t5_lat",   256'(lat), 256'(6));
    check("t5_nbeat", 256'(wq.size()), 256'(4));
    check("t5_beat0", 256'((wq.size() > 0) ? wq[0] : 64'hx), 256'(64'hA0A0_A0A0_0000_0001));
    check("t5_beat3", 256'((wq.size() > 3) ? wq[3] : 64'hx), 256'(64'hD0D0_D0D0_0000_0004));
    check("t5_rdacc", 256'(rd_acc - a0), 256'(0));
    check("t5_resp",  256'(resp_cnt - r0), 256'(1));

    // Reset in the middle of a read burst
    beats[0] = 64'h1111_1111_1111_1111; beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333; beats[3] = 64'h4444_4444_4444_4444;
    r0 = resp_cnt;
    bus.dfp_addr = 32'h0000_0500; bus.dfp_read = 1'b1; bus.bmem_ready = 1'b0;
    tick();
    bus.bmem_ready = 1'b1;
    tick();
    bus.bmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'h0000_0500; bus.bmem_rdata = beats[k];
      tick();
    end
    bus.bmem_rdata = beats[3];
    bus.dfp_read = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_resp",  256'(bus.dfp_resp),   256'(0));
    check("t6_rdata", bus.dfp_rdata,        256'(0));
    check("t6_bread", 256'(bus.bmem_read),  256'(0));
    check("t6_bwr",   256'(bus.bmem_write), 256'(0));
    check("t6_baddr", 256'(bus.bmem_addr),  256'(0));
    check("t6_bwd",   256'(bus.bmem_wdata), 256'(0));
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    bus.bmem_rvalid = 1'b0;
    tick(); tick();
    check("t6_noresp",  256'(resp_cnt - r0), 256'(0));
    check("t6_rdata_z", bus.dfp_rdata, 256'(0));

    beats[0] = 64'h5555_5555_5555_5555; beats[1] = 64'h6666_6666_6666_6666;
    beats[2] = 64'h7777_7777_7777_7777; beats[3] = 64'h8888_8888_8888_8888;
    r0 = resp_cnt;
    run_read(32'h0000_0500, 0, 0, 0, lat, line, rd_hi, aseen);
    tick(); tick();
    check("t6_fresh_line", line, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                  64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
    check("t6_fresh_lat",  256'(lat), 256'(7));
    check("t6_fresh_resp", 256'(resp_cnt - r0), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
